core_inst_sequencer: RTL
========================

Name: core_inst_sequencer

Overview:
- Generates the 35-bit instruction word that drives the accelerator core (activation/weight SRAM, L0, PE array, OFIFO, psum SRAM, SFP).
- One start pulse runs one tile end to end: weight fetch, kernel load, activation fetch, execute, OFIFO drain into psum SRAM, then an optional SFP pass (accumulate/ReLU).
- Sits between the testbench or host controller and the core; it replaces hand-written instruction streams.

Parameters:
- row, 8, PE rows; also the number of weight words per tile.
- col, 8, PE columns.
- l0_depth, 64, maximum activation words per tile.
- kload_cyc, 16, kernel-load cycles (row+col).
- addr_bw, 11, SRAM address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- w_base  in  addr_bw  xmem address of the first weight word.
- x_base  in  addr_bw  xmem address of the first activation word.
- p_base  in  addr_bw  pmem address of the first psum word.
- n_x  in  7  activation/psum word count, 1..l0_depth; sampled at start.
- sfp_en  in  1  run the SFP pass after the drain; sampled at start.
- relu_en  in  1  drives inst[34] during the SFP pass; sampled at start.
- ofifo_valid  in  1  core OFIFO has a word available.
- inst  out  35  registered core instruction word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on exit to IDLE.
- cfg_err  out  1  one-cycle pulse when start is rejected because n_x==0 or n_x>l0_depth.

Behaviour:
- Instruction fields:
  - [1:0]: 01 kernel load, 10 execute, 00 nop.
  - [2] l0_wr, [3] l0_rd, [6] ofifo_rd. Bits [5:4] are always 0.
  - [19] xmem CEN and [18] xmem WEN, both active-low; [17:7] xmem address.
  - [32] pmem CEN and [31] pmem WEN, both active-low; [30:20] pmem address.
  - [33] accumulate, [34] relu.
- IDLE word: bits 19, 18, 32 and 31 high; all other bits 0.
- Reset: inst = IDLE word, busy=0, done=0, cfg_err=0, state=IDLE, all counters 0. Reset asserted mid-tile aborts immediately; no further SRAM writes are issued.
- SRAM latency: a read issued in cycle k has valid Q in cycle k+1. Any consumer of read data (l0_wr, pmem write) therefore asserts one cycle after the read.
- States and transitions:
  - IDLE:
    - start with a valid config: latch config, go to WFETCH.
    - start with an invalid config: pulse cfg_err, stay in IDLE.
    - start while busy: ignored.
  - WFETCH:
    - Issue `row` xmem reads at w_base+i, i=0..row-1 (CEN=0, WEN=1).
    - l0_wr=1 in cycles 1..row relative to the first read, so the state lasts row+1 cycles.
    - Then go to KLOAD.
  - KLOAD:
    - inst[1:0]=01 and l0_rd=1 for kload_cyc cycles.
    - Then one nop cycle, then go to XFETCH.
  - XFETCH:
    - Same read/write pattern as WFETCH, with n_x reads at x_base+i.
    - Then go to EXEC.
  - EXEC:
    - inst[1:0]=10 and l0_rd=1 for n_x cycles.
    - Then go to DRAIN.
  - DRAIN:
    - Track rd_cnt and wr_cnt.
    - ofifo_rd=1 in any cycle where ofifo_valid=1 and rd_cnt<n_x.
    - One cycle after each ofifo_rd: pmem CEN=0, WEN=0, address p_base+wr_cnt.
    - If ofifo_valid is low, wait without timeout.
    - Exit when wr_cnt==n_x: go to SFP if sfp_en, otherwise go to FIN.
  - SFP:
    - n_x pmem reads at p_base+i (CEN=0, WEN=1).
    - inst[33]=1 and inst[34]=relu_en, held for n_x+1 cycles so the last read's data is covered.
    - Then go to FIN.
  - FIN: drive the IDLE word, pulse done, go to IDLE.
- Address arithmetic is modulo 2^addr_bw; base+i wraps silently.
- ofifo_rd and the pmem write overlap in consecutive cycles, so drain throughput is 1 word/cycle when ofifo_valid stays high.
- Fields not named as active in a state hold their IDLE value.

Decomposition:
- Shared package holds:
  - state enum;
  - inst field bit positions (INST_CORELET_LSB, INST_L0_WR, INST_L0_RD, INST_OFIFO_RD, INST_XMEM_CEN, INST_XMEM_WEN, INST_XMEM_ADDR_LSB, INST_PMEM_CEN, INST_PMEM_WEN, INST_PMEM_ADDR_LSB, INST_ACC, INST_RELU);
  - IDLE_WORD constant;
  - CMD_KLOAD/CMD_EXEC encodings.
- One natural sub-module: sram_read_stream (base, count, go → registered address/CEN, plus a 1-cycle-delayed data-valid strobe). It is reused by WFETCH, XFETCH and SFP.

Test Plan:
- Reset, then hold: inst == IDLE word (bits 32, 31, 19, 18 set; value 0x1_800C_0000), busy=0, done=0.
- start with w_base=0, x_base=0x10, p_base=0x40, n_x=4, sfp_en=0, ofifo_valid tied high:
  - xmem addresses 0..7, then 0x10..0x13;
  - l0_wr trails each read by 1 cycle;
  - 16 KLOAD cycles, then 4 EXEC cycles;
  - pmem writes to 0x40..0x43 one cycle after each ofifo_rd;
  - done pulses exactly once.
- Same tile, but ofifo_valid toggles 1,0,0,1,1,0,1 → exactly 4 ofifo_rd and 4 pmem writes, each write 1 cycle after its read, no extra writes.
- sfp_en=1, relu_en=1, n_x=3 → pmem reads at 0x40..0x42 with inst[33]=1 and inst[34]=1 for 4 cycles, then done.
- start with n_x=0, and separately n_x=65 → cfg_err pulse, busy stays 0, inst stays the IDLE word. A start pulse while busy is ignored.
- Assert reset in the third DRAIN cycle → inst returns to the IDLE word immediately and no pmem write follows. A new start runs a full tile correctly.
- Wrap case: p_base=0x7FE, n_x=4 → pmem write addresses 0x7FE, 0x7FF, 0x000, 0x001.

Source files
------------

// File: rtl/core_inst_sequencer_pkg.sv
// Shared state encoding, instruction-word layout and command encodings for the
// core instruction sequencer.
package core_inst_sequencer_pkg;

    localparam int ADDR_BW = 11;
    localparam int INST_W  = 35;
    localparam int CNT_W   = 7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WFETCH,
        S_KLOAD,
        S_XFETCH,
        S_EXEC,
        S_DRAIN,
        S_SFP,
        S_FIN
    } state_e;

    localparam int INST_CORELET_LSB   = 0;
    localparam int INST_L0_WR         = 2;
    localparam int INST_L0_RD         = 3;
    localparam int INST_OFIFO_RD      = 6;
    localparam int INST_XMEM_ADDR_LSB = 7;
    localparam int INST_XMEM_WEN      = 18;
    localparam int INST_XMEM_CEN      = 19;
    localparam int INST_PMEM_ADDR_LSB = 20;
    localparam int INST_PMEM_WEN      = 31;
    localparam int INST_PMEM_CEN      = 32;
    localparam int INST_ACC           = 33;
    localparam int INST_RELU          = 34;

    // Both SRAMs deselected with write-enable inactive; everything else zero.
    localparam logic [INST_W-1:0] IDLE_WORD = 35'h1_800C_0000;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_KLOAD = 2'b01;
    localparam logic [1:0] CMD_EXEC  = 2'b10;

    function automatic logic cfg_ok(input logic [CNT_W-1:0] n, input int depth);
        return (n != {CNT_W{1'b0}}) && (int'(n) <= depth);
    endfunction

endpackage

// File: rtl/core_inst_sequencer_sram_read_stream.sv
// Issues `count` consecutive SRAM reads from `base` after a go pulse; vld_q
// trails rd_q by one cycle, marking when the read data is on Q.
module sram_read_stream
    import core_inst_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [ADDR_BW-1:0] base,
    input  logic [CNT_W-1:0]   count,
    output logic               rd_q,
    output logic [ADDR_BW-1:0] addr_q,
    output logic               vld_q
);

    logic               rd_d;
    logic               vld_d;
    logic [ADDR_BW-1:0] addr_d;
    logic [CNT_W-1:0]   left_q;
    logic [CNT_W-1:0]   left_d;

    // Next read address and remaining-read bookkeeping.
    always_comb begin
        rd_d   = rd_q;
        addr_d = addr_q;
        left_d = left_q;
        vld_d  = rd_q;
        if (go) begin
            rd_d   = 1'b1;
            addr_d = base;
            left_d = count - CNT_W'(1);
        end else if (rd_q) begin
            if (left_q == {CNT_W{1'b0}}) begin
                rd_d = 1'b0;
            end else begin
                addr_d = addr_q + ADDR_BW'(1);
                left_d = left_q - CNT_W'(1);
            end
        end else begin
            rd_d = 1'b0;
        end
    end

    // Stream registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q   <= 1'b0;
            vld_q  <= 1'b0;
            addr_q <= {ADDR_BW{1'b0}};
            left_q <= {CNT_W{1'b0}};
        end else begin
            rd_q   <= rd_d;
            vld_q  <= vld_d;
            addr_q <= addr_d;
            left_q <= left_d;
        end
    end

endmodule

// File: rtl/core_inst_sequencer.sv
// Tile sequencer: one start pulse becomes the full instruction stream for weight
// fetch, kernel load, activation fetch, execute, OFIFO drain and optional SFP.
module core_inst_sequencer
    import core_inst_sequencer_pkg::*;
#(
    parameter int ROW       = 8,
    parameter int COL       = 8,
    parameter int L0_DEPTH  = 64,
    parameter int KLOAD_CYC = ROW + COL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_BW-1:0] w_base,
    input  logic [ADDR_BW-1:0] x_base,
    input  logic [ADDR_BW-1:0] p_base,
    input  logic [CNT_W-1:0]   n_x,
    input  logic               sfp_en,
    input  logic               relu_en,
    input  logic               ofifo_valid,
    output logic [INST_W-1:0]  inst,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [CNT_W-1:0] ROW_N   = CNT_W'(ROW);
    localparam logic [CNT_W-1:0] KLOAD_N = CNT_W'(KLOAD_CYC);

    state_e             state_q, state_d;
    logic [ADDR_BW-1:0] x_base_q, x_base_d, p_base_q, p_base_d;
    logic [CNT_W-1:0]   n_x_q, n_x_d, cnt_q, cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic               sfp_q, sfp_d, relu_q, relu_d, wr_pend_q, wr_pend_d;
    logic [INST_W-1:0]  inst_q, inst_d;
    logic               busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

    logic               rs_go_s;
    logic [ADDR_BW-1:0] rs_base_s;
    logic [CNT_W-1:0]   rs_cnt_s;
    logic               rs_rd_s, rs_vld_s, rs_last_s;
    logic [ADDR_BW-1:0] rs_addr_s;

    sram_read_stream u_stream (
        .clk    (clk),
        .reset  (reset),
        .go     (rs_go_s),
        .base   (rs_base_s),
        .count  (rs_cnt_s),
        .rd_q   (rs_rd_s),
        .addr_q (rs_addr_s),
        .vld_q  (rs_vld_s)
    );

    // The last valid strobe of a stream is the cycle its final read data lands.
    assign rs_last_s = rs_vld_s & ~rs_rd_s;

    // Next-state, counter and instruction-word computation.
    always_comb begin
        state_d   = state_q;
        x_base_d  = x_base_q;
        p_base_d  = p_base_q;
        n_x_d     = n_x_q;
        sfp_d     = sfp_q;
        relu_d    = relu_q;
        cnt_d     = cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        wr_pend_d = 1'b0;
        rs_go_s   = 1'b0;
        rs_base_s = x_base_q;
        rs_cnt_s  = n_x_q;
        inst_d    = IDLE_WORD;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && cfg_ok(n_x, L0_DEPTH)) begin
                    x_base_d  = x_base;
                    p_base_d  = p_base;
                    n_x_d     = n_x;
                    sfp_d     = sfp_en;
                    relu_d    = relu_en;
                    rs_go_s   = 1'b1;
                    rs_base_s = w_base;
                    rs_cnt_s  = ROW_N;
                    state_d   = S_WFETCH;
                end else if (start) begin
                    cfg_err_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WFETCH, S_XFETCH: begin
                inst_d[INST_XMEM_CEN] = ~rs_rd_s;
                inst_d[INST_XMEM_ADDR_LSB +: ADDR_BW] = rs_rd_s ? rs_addr_s : {ADDR_BW{1'b0}};
                inst_d[INST_L0_WR] = rs_vld_s;
                if (rs_last_s) begin
                    state_d = (state_q == S_WFETCH) ? S_KLOAD : S_EXEC;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_KLOAD: begin
                if (cnt_q != KLOAD_N) begin
                    inst_d[INST_CORELET_LSB +: 2] = CMD_KLOAD;
                    inst_d[INST_L0_RD] = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    // Trailing nop cycle; the activation stream starts behind it.
                    rs_go_s   = 1'b1;
                    rs_base_s = x_base_q;
                    rs_cnt_s  = n_x_q;
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = S_XFETCH;
                end
            end
            S_EXEC: begin
                inst_d[INST_CORELET_LSB +: 2] = CMD_EXEC;
                inst_d[INST_L0_RD] = 1'b1;
                if (cnt_q == n_x_q - CNT_W'(1)) begin
                    cnt_d    = {CNT_W{1'b0}};
                    rd_cnt_d = {CNT_W{1'b0}};
                    wr_cnt_d = {CNT_W{1'b0}};
                    state_d  = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (ofifo_valid && (rd_cnt_q != n_x_q)) begin
                    inst_d[INST_OFIFO_RD] = 1'b1;
                    rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                    wr_pend_d = 1'b1;
                end else begin
                    wr_pend_d = 1'b0;
                end
                // The OFIFO word read last cycle is on its output now: store it.
                if (wr_pend_q) begin
                    inst_d[INST_PMEM_CEN] = 1'b0;
                    inst_d[INST_PMEM_WEN] = 1'b0;
                    inst_d[INST_PMEM_ADDR_LSB +: ADDR_BW] = p_base_q + ADDR_BW'(wr_cnt_q);
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    if (wr_cnt_q == n_x_q - CNT_W'(1)) begin
                        if (sfp_q) begin
                            rs_go_s   = 1'b1;
                            rs_base_s = p_base_q;
                            rs_cnt_s  = n_x_q;
                            state_d   = S_SFP;
                        end else begin
                            state_d = S_FIN;
                        end
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_SFP: begin
                inst_d[INST_PMEM_CEN] = ~rs_rd_s;
                inst_d[INST_PMEM_ADDR_LSB +: ADDR_BW] = rs_rd_s ? rs_addr_s : {ADDR_BW{1'b0}};
                inst_d[INST_ACC]  = 1'b1;
                inst_d[INST_RELU] = relu_q;
                if (rs_last_s) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_SFP;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_base_q  <= {ADDR_BW{1'b0}};
            p_base_q  <= {ADDR_BW{1'b0}};
            n_x_q     <= {CNT_W{1'b0}};
            sfp_q     <= 1'b0;
            relu_q    <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            rd_cnt_q  <= {CNT_W{1'b0}};
            wr_cnt_q  <= {CNT_W{1'b0}};
            wr_pend_q <= 1'b0;
            inst_q    <= IDLE_WORD;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_base_q  <= x_base_d;
            p_base_q  <= p_base_d;
            n_x_q     <= n_x_d;
            sfp_q     <= sfp_d;
            relu_q    <= relu_d;
            cnt_q     <= cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_pend_q <= wr_pend_d;
            inst_q    <= inst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign inst    = inst_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule
